// File: rtl/owl_dma_pkg.sv
// Shared types and default widths for the OWL DMA write arbiter.
package owl_dma_pkg;

  localparam int DEF_AW = 32;
  localparam int DEF_DW = 32;
  localparam int DEF_BL = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

endpackage

// File: rtl/owl_rr_arb.sv
// Combinational NM-way round-robin picker: searches upward from ptr with
// wrap-around and returns the first requester as a one-hot vector.
module owl_rr_arb #(
  parameter int NM = 2,
  parameter int PW = 1
) (
  input  logic [NM-1:0] req,
  input  logic [PW-1:0] ptr,
  output logic [NM-1:0] win
);

  logic          found;
  logic [PW:0]   idx;

  // Walk the masters starting at the pointer; the first requester wins.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NM; k++) begin
      idx = {1'b0, ptr} + (PW+1)'(k);
      if (idx >= (PW+1)'(NM)) idx = idx - (PW+1)'(NM);
      if (!found && req[idx[PW-1:0]]) begin
        win[idx[PW-1:0]] = 1'b1;
        found            = 1'b1;
      end
    end
  end

endmodule

// File: rtl/owl_dma_wr_arb.sv
// Burst-granular round-robin arbiter that lets NM DMA write masters share
// one write bus. A master owns the bus for wlen+1 beats; one idle cycle
// always separates consecutive bursts.
module owl_dma_wr_arb
  import owl_dma_pkg::*;
#(
  parameter int NM = 2,
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW,
  parameter int BL = DEF_BL
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NM-1:0]    m_wval,
  output logic [NM-1:0]    m_wrdy,
  input  logic [NM*BL-1:0] m_wlen,
  input  logic [NM*AW-1:0] m_waddr,
  input  logic [NM*DW-1:0] m_wdata,
  output logic             bus_wval,
  input  logic             bus_wrdy,
  output logic [BL-1:0]    bus_wlen,
  output logic [AW-1:0]    bus_waddr,
  output logic [DW-1:0]    bus_wdata,
  output logic [NM-1:0]    grant,
  output logic             busy
);

  localparam int PW = $clog2(NM);

  state_t          state_q;
  logic [NM-1:0]   grant_q;
  logic [PW-1:0]   ptr_q;
  logic [BL-1:0]   cnt_q;
  logic [BL-1:0]   len_q;

  logic [NM-1:0]   win;
  logic [PW-1:0]   gidx;
  logic [BL-1:0]   win_len;
  logic            beat;

  owl_rr_arb #(
    .NM (NM),
    .PW (PW)
  ) u_rr (
    .req (m_wval),
    .ptr (ptr_q),
    .win (win)
  );

  // Burst length of the arbitration winner and index of the current owner.
  always_comb begin
    win_len = '0;
    gidx    = '0;
    for (int i = 0; i < NM; i++) begin
      if (win[i])     win_len = m_wlen[i*BL +: BL];
      if (grant_q[i]) gidx    = PW'(i);
    end
  end

  // Route the owner onto the bus; an all-zero grant drives zeros.
  always_comb begin
    bus_wval  = 1'b0;
    bus_wlen  = '0;
    bus_waddr = '0;
    bus_wdata = '0;
    for (int i = 0; i < NM; i++) begin
      if (grant_q[i]) begin
        bus_wval  = m_wval[i];
        bus_wlen  = m_wlen[i*BL +: BL];
        bus_waddr = m_waddr[i*AW +: AW];
        bus_wdata = m_wdata[i*DW +: DW];
      end
    end
  end

  assign m_wrdy = grant_q & {NM{bus_wrdy}};
  assign beat   = bus_wval & bus_wrdy;
  assign grant  = grant_q;
  assign busy   = (state_q == ST_BURST);

  // Ownership FSM: grant on request, count beats, release after the last one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|m_wval) begin
            state_q <= ST_BURST;
            grant_q <= win;
            cnt_q   <= '0;
            len_q   <= win_len;
          end
        end
        ST_BURST: begin
          if (beat) begin
            if (cnt_q == len_q) begin
              state_q <= ST_IDLE;
              grant_q <= '0;
              ptr_q   <= (gidx == PW'(NM-1)) ? '0 : gidx + 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_owl_dma_wr_arb.sv
// Directed bench for owl_dma_wr_arb with two masters: a per-cycle vector
// table plus hand-written max-burst and mid-burst reset sequences.
module tb_owl_dma_wr_arb;

  localparam int NM = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BL = 4;

  localparam logic [AW-1:0] ADDR0 = 32'h0000_0100;
  localparam logic [AW-1:0] ADDR1 = 32'h0000_0200;
  localparam logic [DW-1:0] DATA0 = 32'hD0D0_0000;
  localparam logic [DW-1:0] DATA1 = 32'hD1D1_0001;

  logic             clk;
  logic             rst_n;
  logic [NM-1:0]    m_wval;
  logic [NM-1:0]    m_wrdy;
  logic [NM*BL-1:0] m_wlen;
  logic [NM*AW-1:0] m_waddr;
  logic [NM*DW-1:0] m_wdata;
  logic             bus_wval;
  logic             bus_wrdy;
  logic [BL-1:0]    bus_wlen;
  logic [AW-1:0]    bus_waddr;
  logic [DW-1:0]    bus_wdata;
  logic [NM-1:0]    grant;
  logic             busy;

  int n_tests;
  int n_fail;

  owl_dma_wr_arb #(
    .NM (NM),
    .AW (AW),
    .DW (DW),
    .BL (BL)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .m_wval    (m_wval),
    .m_wrdy    (m_wrdy),
    .m_wlen    (m_wlen),
    .m_waddr   (m_waddr),
    .m_wdata   (m_wdata),
    .bus_wval  (bus_wval),
    .bus_wrdy  (bus_wrdy),
    .bus_wlen  (bus_wlen),
    .bus_waddr (bus_waddr),
    .bus_wdata (bus_wdata),
    .grant     (grant),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rst_n;
    logic [1:0]    wval;
    logic [BL-1:0] len0;
    logic [BL-1:0] len1;
    logic          wrdy;
    logic [1:0]    e_grant;
    logic          e_busy;
    logic          e_bvld;
    logic [1:0]    e_mrdy;
    logic [BL-1:0] e_len;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t v(int r, int w, int l0, int l1, int rdy,
                             int g, int b, int bv, int mr, int el);
    vec_t o;
    o.rst_n   = r[0];
    o.wval    = w[1:0];
    o.len0    = l0[BL-1:0];
    o.len1    = l1[BL-1:0];
    o.wrdy    = rdy[0];
    o.e_grant = g[1:0];
    o.e_busy  = b[0];
    o.e_bvld  = bv[0];
    o.e_mrdy  = mr[1:0];
    o.e_len   = el[BL-1:0];
    return o;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    int            beats;
    string         tag;

    n_tests  = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    m_wval   = '0;
    m_wlen   = '0;
    bus_wrdy = 1'b0;
    m_waddr  = {ADDR1, ADDR0};
    m_wdata  = {DATA1, DATA0};
    repeat (2) @(posedge clk);
    #1;

    //        rst wval l0 l1 rdy  grant busy bvld mrdy elen
    // single master, wlen=3: grant one cycle after request, 4 beats
    vq.push_back(v(0, 1, 3, 0, 1,  0, 0, 0, 0, 0));
    vq.push_back(v(1, 1, 3, 0, 1,  0, 0, 0, 0, 0));
    vq.push_back(v(1, 1, 3, 0, 1,  1, 1, 1, 1, 3));
    vq.push_back(v(1, 1, 3, 0, 1,  1, 1, 1, 1, 3));
    vq.push_back(v(1, 1, 3, 0, 1,  1, 1, 1, 1, 3));
    vq.push_back(v(1, 1, 3, 0, 1,  1, 1, 1, 1, 3));
    vq.push_back(v(1, 0, 3, 0, 1,  0, 0, 0, 0, 0));
    // contention from reset: m0, idle gap, m1, idle gap, m0 again
    vq.push_back(v(0, 3, 1, 1, 1,  0, 0, 0, 0, 0));
    vq.push_back(v(1, 3, 1, 1, 1,  0, 0, 0, 0, 0));
    vq.push_back(v(1, 3, 1, 1, 1,  1, 1, 1, 1, 1));
    vq.push_back(v(1, 3, 1, 1, 1,  1, 1, 1, 1, 1));
    vq.push_back(v(1, 3, 1, 1, 1,  0, 0, 0, 0, 0));
    vq.push_back(v(1, 3, 1, 1, 1,  2, 1, 1, 2, 1));
    vq.push_back(v(1, 3, 1, 1, 1,  2, 1, 1, 2, 1));
    vq.push_back(v(1, 3, 1, 1, 1,  0, 0, 0, 0, 0));
    vq.push_back(v(1, 3, 1, 1, 1,  1, 1, 1, 1, 1));
    vq.push_back(v(1, 3, 1, 1, 1,  1, 1, 1, 1, 1));
    // pointer at 1, only m0 requests: wrap gives m0 a single-beat burst
    vq.push_back(v(1, 1, 0, 0, 1,  0, 0, 0, 0, 0));
    vq.push_back(v(1, 1, 0, 0, 1,  1, 1, 1, 1, 0));
    vq.push_back(v(1, 0, 0, 0, 1,  0, 0, 0, 0, 0));
    // backpressure on a wlen=2 burst: ready 1,0,1,0,1 -> 3 beats
    vq.push_back(v(1, 1, 2, 0, 1,  0, 0, 0, 0, 0));
    vq.push_back(v(1, 1, 2, 0, 1,  1, 1, 1, 1, 2));
    vq.push_back(v(1, 1, 2, 0, 0,  1, 1, 1, 0, 2));
    vq.push_back(v(1, 1, 2, 0, 1,  1, 1, 1, 1, 2));
    vq.push_back(v(1, 1, 2, 0, 0,  1, 1, 1, 0, 2));
    vq.push_back(v(1, 1, 2, 0, 1,  1, 1, 1, 1, 2));
    vq.push_back(v(1, 0, 2, 0, 1,  0, 0, 0, 0, 0));
    // m1 stalls 5 cycles after 2 beats while m0 requests (ignored)
    vq.push_back(v(1, 2, 0, 3, 1,  0, 0, 0, 0, 0));
    vq.push_back(v(1, 2, 0, 3, 1,  2, 1, 1, 2, 3));
    vq.push_back(v(1, 2, 0, 3, 1,  2, 1, 1, 2, 3));
    vq.push_back(v(1, 1, 0, 3, 1,  2, 1, 0, 2, 3));
    vq.push_back(v(1, 1, 0, 3, 1,  2, 1, 0, 2, 3));
    vq.push_back(v(1, 1, 0, 3, 1,  2, 1, 0, 2, 3));
    vq.push_back(v(1, 1, 0, 3, 1,  2, 1, 0, 2, 3));
    vq.push_back(v(1, 1, 0, 3, 1,  2, 1, 0, 2, 3));
    vq.push_back(v(1, 2, 0, 3, 1,  2, 1, 1, 2, 3));
    vq.push_back(v(1, 2, 0, 3, 1,  2, 1, 1, 2, 3));
    vq.push_back(v(1, 0, 0, 3, 1,  0, 0, 0, 0, 0));

    foreach (vq[n]) begin
      rst_n    = vq[n].rst_n;
      m_wval   = vq[n].wval;
      m_wlen   = {vq[n].len1, vq[n].len0};
      bus_wrdy = vq[n].wrdy;
      #2;
      e_addr = (vq[n].e_grant == 2'b01) ? ADDR0 : (vq[n].e_grant == 2'b10) ? ADDR1 : '0;
      e_data = (vq[n].e_grant == 2'b01) ? DATA0 : (vq[n].e_grant == 2'b10) ? DATA1 : '0;
      tag = $sformatf("v%0d", n);
      check({tag, ".grant"},     64'(grant),     64'(vq[n].e_grant));
      check({tag, ".busy"},      64'(busy),      64'(vq[n].e_busy));
      check({tag, ".bus_wval"},  64'(bus_wval),  64'(vq[n].e_bvld));
      check({tag, ".m_wrdy"},    64'(m_wrdy),    64'(vq[n].e_mrdy));
      check({tag, ".bus_wlen"},  64'(bus_wlen),  64'(vq[n].e_len));
      check({tag, ".bus_waddr"}, 64'(bus_waddr), 64'(e_addr));
      check({tag, ".bus_wdata"}, 64'(bus_wdata), 64'(e_data));
      tick();
    end

    // max burst: pointer is 0, m0 wlen=15 -> 16 beats then idle
    m_wval   = 2'b01;
    m_wlen   = {4'd0, 4'd15};
    bus_wrdy = 1'b1;
    tick();
    check("max.grant", 64'(grant), 64'(2'b01));
    check("max.wlen",  64'(bus_wlen), 64'(4'd15));
    beats = 0;
    for (int c = 0; c < 40 && busy; c++) begin
      if (bus_wval && bus_wrdy) beats++;
      tick();
    end
    check("max.beats", 64'(beats), 64'(16));
    check("max.busy_end",  64'(busy),  64'(0));
    check("max.grant_end", 64'(grant), 64'(2'b00));
    m_wval = 2'b00;
    tick();

    // reset after 2 of 8 beats from m1; pointer must return to 0
    m_wval = 2'b10;
    m_wlen = {4'd7, 4'd0};
    tick();
    check("rst.grant_m1", 64'(grant), 64'(2'b10));
    tick();
    tick();
    check("rst.still_busy", 64'(busy), 64'(1));
    rst_n = 1'b0;
    tick();
    check("rst.grant",    64'(grant),    64'(2'b00));
    check("rst.bus_wval", 64'(bus_wval), 64'(0));
    check("rst.busy",     64'(busy),     64'(0));
    check("rst.m_wrdy",   64'(m_wrdy),   64'(2'b00));
    m_wval = 2'b11;
    m_wlen = '0;
    tick();
    rst_n = 1'b1;
    #1;
    check("rst.idle_grant", 64'(grant), 64'(2'b00));
    tick();
    check("rst.ptr0_grant", 64'(grant), 64'(2'b01));
    check("rst.ptr0_addr",  64'(bus_waddr), 64'(ADDR0));
    m_wval = 2'b00;
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
